// File: rtl/fft_bitrev_buf.sv
// Purpose: 64-point FFT input reorder buffer. Natural-order samples go into two ping-pong banks and each frame is replayed in 6-bit bit-reversed order.
// Latency: output k=0 is registered one edge after the frame's last input sample is written; a frame then streams out over 64 consecutive edges.
// Backpressure: rdy_o drops only while both banks hold unread frames. The output side has no stall input and always drains at one sample per clock.
module fft_bitrev_buf #(
  parameter int DATA_WD = 16,
  parameter int FFT_PT  = 64,
  parameter int FFT_LOG = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 val_i,
  input  logic [2*DATA_WD-1:0] dat_i,
  output logic                 rdy_o,
  output logic                 val_o,
  output logic [2*DATA_WD-1:0] dat_o,
  output logic [FFT_LOG-1:0]   idx_o,
  output logic                 sof_o,
  output logic                 eof_o
);

  localparam int                 SMP_WD = 2 * DATA_WD;
  localparam logic [FFT_LOG-1:0] LAST   = FFT_LOG'(FFT_PT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } rd_state_e;

  // Two banks laid out back to back. The bank select is the address MSB.
  logic [SMP_WD-1:0]  mem_q [0:2*FFT_PT-1];

  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic [FFT_LOG-1:0] wr_cnt_q, wr_cnt_d;
  logic               rd_bank_q;
  logic [FFT_LOG-1:0] rd_cnt_q;
  rd_state_e          state_q;

  logic               wr_acc;
  logic               wr_last;
  logic               rd_fire;
  logic               rd_last;
  logic [FFT_LOG-1:0] rd_addr;

  function automatic logic [FFT_LOG-1:0] bitrev(input logic [FFT_LOG-1:0] a);
    logic [FFT_LOG-1:0] r;
    r = '0;
    for (int i = 0; i < FFT_LOG; i++) begin
      r[i] = a[FFT_LOG-1-i];
    end
    return r;
  endfunction

  // A bank is writable only while it holds no unread frame.
  assign rdy_o = !full_q[wr_bank_q];

  // Next-state for the write pointer and the per-bank full flags.
  always_comb begin
    wr_acc    = val_i && rdy_o;
    wr_last   = wr_acc && (wr_cnt_q == LAST);
    // READ always implies the current bank is full. Firing on the full flag
    // while in IDLE gives output k=0 on the edge right after the last write.
    rd_fire   = (state_q == ST_READ) || full_q[rd_bank_q];
    rd_last   = rd_fire && (rd_cnt_q == LAST);
    rd_addr   = bitrev(rd_cnt_q);
    wr_cnt_d  = wr_acc ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wr_bank_d = wr_last ? ~wr_bank_q : wr_bank_q;
    full_d    = full_q;
    // Set and clear always target different banks: a bank being read is full,
    // so it can never be the bank that is being written.
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
  end

  // Sample storage has no reset; stale contents are never read because the full flags are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[{wr_bank_q, wr_cnt_q}] <= dat_i;
  end

  // Write pointer and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Read FSM with registered outputs. It emits one bit-reversed sample per edge while a frame is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      val_o     <= 1'b0;
      dat_o     <= '0;
      idx_o     <= '0;
      sof_o     <= 1'b0;
      eof_o     <= 1'b0;
    end else begin
      val_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      if (rd_fire) begin
        dat_o    <= mem_q[{rd_bank_q, rd_addr}];
        idx_o    <= rd_cnt_q;
        val_o    <= 1'b1;
        sof_o    <= (rd_cnt_q == '0);
        eof_o    <= (rd_cnt_q == LAST);
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (rd_last) begin
          rd_bank_q <= ~rd_bank_q;
          // If the other bank's last write lands on this same edge, its flag
          // is not visible yet. IDLE then picks it up on the next edge, so
          // the output still has no gap.
          state_q   <= full_q[~rd_bank_q] ? ST_READ : ST_IDLE;
        end else begin
          state_q   <= ST_READ;
        end
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

endmodule
